// File: rtl/fp_pkg.sv
// Shared floating-point datapath package: mantissa-derived widths, the
// exponent-adjustment type and the overflow adjustment constant.
package fp_pkg;

  localparam int DEFAULT_MANT_W = 23;

  // Width of the double-width mantissa product for a given fraction width.
  function automatic int fp_pw(input int mant_w);
    return 2 * (mant_w + 1);
  endfunction

  // Width of the signed exponent adjustment (leading-one position plus sign).
  function automatic int fp_shift_w(input int mant_w);
    return $clog2(fp_pw(mant_w)) + 1;
  endfunction

  typedef logic signed [fp_shift_w(DEFAULT_MANT_W)-1:0] exp_adj_t;

  // Adjustment applied when the mantissa overflows one position upward.
  localparam int EXP_ADJ_OVF = -1;

endpackage

// File: rtl/lead_one_det.sv
// Leading-one detector: reports the index of the most significant set bit
// of vec and flags an all-zero input.
module lead_one_det #(
  parameter int W = 48
) (
  input  logic [W-1:0]         vec,
  output logic [$clog2(W)-1:0] pos,
  output logic                 zero
);

  localparam int POS_W = $clog2(W);

  // Scan upward so the highest set bit is the last one to win.
  always_comb begin
    pos  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        pos  = POS_W'(i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_mant_normalizer.sv
// Two-stage mantissa product normaliser with valid/ready handshake.
// Stage 1 captures the product and its leading-one position; stage 2
// shifts, extracts the fraction and (optionally) rounds.
// Build option: define FP_NORM_ROUND_EN for round-to-nearest-even;
// otherwise the fraction is truncated.
module fp_mant_normalizer
  import fp_pkg::*;
#(
  parameter  int MANT_W  = 23,
  parameter  int TAG_W   = 8,
  localparam int PW      = fp_pw(MANT_W),
  localparam int SHIFT_W = fp_shift_w(MANT_W)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PW-1:0]             in_prod,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MANT_W-1:0]         out_frac,
  output logic signed [SHIFT_W-1:0] out_exp_adj,
  output logic                      out_zero,
  output logic                      out_inexact,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int POS_W = SHIFT_W - 1;

  logic              s1_valid;
  logic [PW-1:0]     s1_prod;
  logic [TAG_W-1:0]  s1_tag;
  logic [POS_W-1:0]  s1_pos;
  logic              s1_zero;
  logic              s2_adv;
  logic              s1_adv;
  logic [POS_W-1:0]  lod_pos;
  logic              lod_zero;

  logic [POS_W-1:0]          shamt;
  logic [PW-1:0]             norm;
  logic [MANT_W-1:0]         frac_c;
  logic signed [SHIFT_W-1:0] adj_c;
  logic                      guard;
  logic                      sticky;
  logic                      inexact_c;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  lead_one_det #(.W(PW)) u_lod (
    .vec  (in_prod),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  // Stage 1: capture product, tag and leading-one information on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_tag   <= '0;
      s1_pos   <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_prod <= in_prod;
        s1_tag  <= in_tag;
        s1_pos  <= lod_pos;
        s1_zero <= lod_zero;
      end
    end
  end

  // Normalise so the leading one sits at the top bit, then slice the
  // fraction below it; a product with its top bit set yields adj = -1.
  always_comb begin
    shamt     = POS_W'(PW - 1) - s1_pos;
    norm      = s1_prod << shamt;
    guard     = norm[MANT_W];
    sticky    = |norm[MANT_W-1:0];
    inexact_c = guard | sticky;
    adj_c     = s1_zero ? '0 : ($signed(SHIFT_W'(PW - 2)) - $signed({1'b0, s1_pos}));
    frac_c    = norm[PW-2:MANT_W+1];
`ifdef FP_NORM_ROUND_EN
    if (guard & (sticky | frac_c[0])) begin
      if (&frac_c) begin
        adj_c = adj_c + $signed(SHIFT_W'(EXP_ADJ_OVF));
      end
      frac_c = frac_c + MANT_W'(1);
    end
`endif
  end

  // Stage 2: register the normalised result; hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_frac    <= '0;
      out_exp_adj <= '0;
      out_zero    <= 1'b0;
      out_inexact <= 1'b0;
      out_tag     <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_frac    <= frac_c;
        out_exp_adj <= adj_c;
        out_zero    <= s1_zero;
        out_inexact <= inexact_c;
        out_tag     <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_mant_normalizer.sv
// Self-checking bench for fp_mant_normalizer (default MANT_W=23, TAG_W=8).
// Build option: FP_NORM_ROUND_EN selects the rounding expectations.
module tb_fp_mant_normalizer;

  typedef struct {
    longint frac;
    longint adj;
    longint zero;
    longint inexact;
    longint tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_prod = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [22:0] out_frac;
  logic signed [6:0] out_exp_adj;
  logic        out_zero;
  logic        out_inexact;
  logic [7:0]  out_tag;

  int   checks = 0;
  int   errors = 0;
  exp_t pend[$];
  bit   stall_prev = 1'b0;
  exp_t held;

  fp_mant_normalizer #(.MANT_W(23), .TAG_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_prod     (in_prod),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_frac    (out_frac),
    .out_exp_adj (out_exp_adj),
    .out_zero    (out_zero),
    .out_inexact (out_inexact),
    .out_tag     (out_tag)
  );

  always #5 clk = ~clk;

  // Reference: normalise by arithmetic on a 48-bit value, then round.
  function automatic exp_t model(input longint unsigned prod, input longint tag);
    exp_t e;
    int p;
    longint unsigned n;
    longint unsigned g;
    bit s;
    e.tag = tag; e.frac = 0; e.adj = 0; e.zero = 0; e.inexact = 0;
    if (prod == 0) begin
      e.zero = 1;
      return e;
    end
    p = 0;
    for (int i = 0; i < 48; i++) if (((prod >> i) & 64'd1) != 0) p = i;
    n = (prod << (47 - p)) & 64'hFFFF_FFFF_FFFF;
    e.frac = longint'((n >> 24) & 64'h7F_FFFF);
    g = (n >> 23) & 64'd1;
    s = (n % 64'd8388608) != 0;
    e.adj = 46 - p;
    e.inexact = (g != 0 || s) ? 1 : 0;
`ifdef FP_NORM_ROUND_EN
    if (g != 0 && (s || (e.frac % 2) == 1)) begin
      e.frac = e.frac + 1;
      if (e.frac == 64'd8388608) begin
        e.frac = 0;
        e.adj = e.adj - 1;
      end
    end
`endif
    return e;
  endfunction

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic compare_result(input string name, input exp_t e);
    check_output({name, ".frac"}, longint'(out_frac), e.frac);
    check_output({name, ".exp_adj"}, longint'($signed(out_exp_adj)), e.adj);
    check_output({name, ".zero"}, longint'(out_zero), e.zero);
    check_output({name, ".inexact"}, longint'(out_inexact), e.inexact);
    check_output({name, ".tag"}, longint'(out_tag), e.tag);
  endtask

  // Monitor: ready rule, stall stability, scoreboard pop and push.
  always @(negedge clk) begin
    if (rst_n) begin
      check_output("in_ready_rule", longint'(in_ready),
                   (pend.size() == 2 && !out_ready) ? 0 : 1);
      if (stall_prev) begin
        check_output("stall_valid", longint'(out_valid), 1);
        compare_result("stall_hold", held);
      end
      stall_prev = out_valid && !out_ready;
      if (stall_prev) begin
        held.frac = longint'(out_frac);
        held.adj = longint'($signed(out_exp_adj));
        held.zero = longint'(out_zero);
        held.inexact = longint'(out_inexact);
        held.tag = longint'(out_tag);
      end
      if (out_valid && out_ready) begin
        if (pend.size() == 0) begin
          check_output("unexpected_output", 1, 0);
        end else begin
          compare_result("result", pend.pop_front());
        end
      end
      if (in_valid && in_ready) pend.push_back(model(longint'(in_prod), longint'(in_tag)));
    end
  end

  task automatic apply_stimulus(input logic [47:0] prod, input logic [7:0] tag);
    bit acc;
    in_valid = 1'b1;
    in_prod  = prod;
    in_tag   = tag;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check_output("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (pend.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("drain_left", longint'(pend.size()), 0);
  endtask

  logic [47:0] stream [16] = '{
    48'h8000_0000_0000, 48'h4000_0040_0000, 48'h4000_00C0_0000, 48'h7FFF_FFFF_FFFF,
    48'h0000_0000_0001, 48'h0000_0000_0000, 48'hFFFF_FFFF_FFFF, 48'h0012_3456_789A,
    48'h0000_0100_0000, 48'hC000_0000_0001, 48'h0000_FFFF_FFFF, 48'h5555_5555_5555,
    48'h0000_0000_8000, 48'hA5A5_A5A5_A5A5, 48'h4000_0000_0000, 48'h0FFF_FF80_0000};

  initial begin
    exp_t e;
    int idx;
    int cyc;
    logic [63:0] r;

    // Hand-computed expectations that pin the model itself.
    e = model(64'h8000_0000_0000, 0);
    check_output("pin_top.frac", e.frac, 0);
    check_output("pin_top.adj", e.adj, -1);
    check_output("pin_top.inexact", e.inexact, 0);
    e = model(64'h1, 0);
    check_output("pin_one.adj", e.adj, 46);
    check_output("pin_one.frac", e.frac, 0);
    e = model(64'h0, 0);
    check_output("pin_zero.zero", e.zero, 1);
    check_output("pin_zero.adj", e.adj, 0);
    e = model(64'h4000_0040_0000, 0);
    check_output("pin_tie.frac", e.frac, 0);
    check_output("pin_tie.inexact", e.inexact, 1);
    e = model(64'h4000_00C0_0000, 0);
`ifdef FP_NORM_ROUND_EN
    check_output("pin_up.frac", e.frac, 2);
`else
    check_output("pin_up.frac", e.frac, 1);
`endif
    e = model(64'h7FFF_FFFF_FFFF, 0);
`ifdef FP_NORM_ROUND_EN
    check_output("pin_carry.frac", e.frac, 0);
    check_output("pin_carry.adj", e.adj, -1);
`else
    check_output("pin_carry.frac", e.frac, 64'h7F_FFFF);
    check_output("pin_carry.adj", e.adj, 0);
`endif
    e = model(64'hFFFF_FFFF_FFFF, 0);
`ifdef FP_NORM_ROUND_EN
    check_output("pin_carry_top.adj", e.adj, -2);
`else
    check_output("pin_carry_top.adj", e.adj, -1);
`endif

    // Reset and release.
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_out_valid", longint'(out_valid), 0);
    check_output("reset_out_frac", longint'(out_frac), 0);
    check_output("reset_out_tag", longint'(out_tag), 0);
    rst_n = 1'b1;
    check_output("reset_in_ready", longint'(in_ready), 1);

    // Test 1: top-bit product and two-cycle latency.
    apply_stimulus(48'h8000_0000_0000, 8'h11);
    check_output("lat_cycle1", longint'(out_valid), 0);
    @(posedge clk); #1;
    check_output("lat_cycle2", longint'(out_valid), 1);
    check_output("t1.frac", longint'(out_frac), 0);
    check_output("t1.adj", longint'($signed(out_exp_adj)), -1);
    check_output("t1.zero", longint'(out_zero), 0);
    check_output("t1.inexact", longint'(out_inexact), 0);
    check_output("t1.tag", longint'(out_tag), 8'h11);
    drain();

    // Tests 2 and 3: directed boundary vectors.
    apply_stimulus(48'h0000_0000_0001, 8'h21);
    apply_stimulus(48'h0000_0000_0000, 8'h22);
    apply_stimulus(48'h4000_0040_0000, 8'h31);
    apply_stimulus(48'h4000_00C0_0000, 8'h32);
    apply_stimulus(48'h7FFF_FFFF_FFFF, 8'h33);
    apply_stimulus(48'hFFFF_FFFF_FFFF, 8'h34);
    drain();

    // Test 4: back-to-back stream with a five-cycle consumer stall.
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      bit acc;
      in_valid  = 1'b1;
      in_prod   = stream[idx];
      in_tag    = 8'(8'h40 + idx);
      out_ready = !(cyc >= 6 && cyc < 11);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    check_output("stream_sent", idx, 16);
    drain();

    // Test 5: reset with both stages occupied.
    out_ready = 1'b0;
    apply_stimulus(48'h1234_5678_9ABC, 8'h51);
    apply_stimulus(48'h0000_0000_00FF, 8'h52);
    @(posedge clk); #1;
    check_output("full_out_valid", longint'(out_valid), 1);
    check_output("full_in_ready", longint'(in_ready), 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_out_valid", longint'(out_valid), 0);
    pend.delete();
    stall_prev = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check_output("post_reset_in_ready", longint'(in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_output("no_stale_output", longint'(out_valid), 0);
    end

    // Test 6: random products with random handshake pressure.
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 9) < 7);
      in_prod   = r[47:0] >> $urandom_range(0, 48);
      in_tag    = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 8);
      @(posedge clk);
      #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
